// File: rtl/dma_burst_fifo.sv
// dma_burst_fifo
//
// Purpose:
//   Elastic buffer that sits directly after the AXI DMA burst reader. The
//   reader pushes a 32-bit word stream with no backpressure. This block raises
//   o_room only when a whole burst plus slack is certain to fit, so the reader
//   starts a burst only when every word of it can land. Words leave through a
//   first-word-fall-through valid/ready output register.
//
// Ports:
//   clk         in   clock, everything on posedge
//   reset       in   asynchronous active-high reset
//   i_clear     in   synchronous flush of contents and overflow flag
//   i_data      in   write word from the DMA reader
//   i_valid     in   write strobe (no backpressure)
//   o_room      out  at least BURST_LEN+SLACK free array entries (registered)
//   o_data      out  output register word
//   o_valid     out  o_data holds a word
//   i_ready     in   consumer takes o_data this cycle
//   o_level     out  words held = array count + o_valid
//   o_overflow  out  sticky flag: a write was dropped because the array was full

module dma_burst_fifo #(
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = 16,
  parameter int SLACK     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic [31:0]                i_data,
  input  logic                       i_valid,
  output logic                       o_room,
  output logic [31:0]                o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH)+1:0]   o_level,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 2;
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] C_NEED  = LW'(BURST_LEN + SLACK);

  // Pointers wrap for free only when DEPTH is a power of two, and a burst
  // plus slack must fit in an empty array or o_room could never rise.
  if ((DEPTH < BURST_LEN + SLACK) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_badParams
    $error("dma_burst_fifo: DEPTH must be a power of 2 and >= BURST_LEN+SLACK");
  end

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_mcount;
  logic [31:0]   r_odata;
  logic          r_ovalid;
  logic          r_overflow;
  logic          r_room;

  logic          w_load;
  logic [LW-1:0] w_afterRead;
  logic          w_wrAccept;
  logic          w_wrDrop;
  logic [LW-1:0] w_mcountNext;
  logic          w_roomNext;

  // The output register refills whenever it is empty or being popped and the
  // array has something. The full test for a write uses the count after that
  // read, so a full array that is read in the same cycle still accepts a word.
  assign w_load       = (!r_ovalid || i_ready) && (r_mcount != '0);
  assign w_afterRead  = r_mcount - LW'(w_load);
  assign w_wrAccept   = i_valid && (w_afterRead < C_DEPTH);
  assign w_wrDrop     = i_valid && !w_wrAccept;
  assign w_mcountNext = w_afterRead + LW'(w_wrAccept);
  assign w_roomNext   = (C_DEPTH - w_mcountNext) >= C_NEED;

  // Storage array has no reset; the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (w_wrAccept && !i_clear) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers, count and flags. Clear wins over any write or pop in its cycle;
  // o_data simply holds across a clear since o_valid marks it stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mcount   <= '0;
      r_odata    <= '0;
      r_ovalid   <= 1'b0;
      r_overflow <= 1'b0;
      r_room     <= 1'b1;
    end else if (i_clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_mcount   <= '0;
      r_ovalid   <= 1'b0;
      r_overflow <= 1'b0;
      r_room     <= 1'b1;
    end else begin
      if (w_wrAccept) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_wrDrop) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_odata  <= r_mem[r_rptr];
        r_rptr   <= r_rptr + 1'b1;
        r_ovalid <= 1'b1;
      end else if (i_ready) begin
        r_ovalid <= 1'b0;
      end
      r_mcount <= w_mcountNext;
      r_room   <= w_roomNext;
    end
  end

  assign o_data     = r_odata;
  assign o_valid    = r_ovalid;
  assign o_room     = r_room;
  assign o_overflow = r_overflow;
  assign o_level    = r_mcount + LW'(r_ovalid);

endmodule

// File: tb/tb_dma_burst_fifo.sv
// tb_dma_burst_fifo
//
// Purpose:
//   Self-checking bench for dma_burst_fifo. A queue-based reference model
//   tracks the array contents and the output slot; every cycle the DUT
//   outputs are compared against it. Directed scenarios cover latency,
//   room threshold, overflow, full-with-pop, clear and async reset, then a
//   randomized run with varying consumer readiness follows.
//
// Ports: none (top-level bench).

module tb_dma_burst_fifo;

  localparam int DEPTH     = 64;
  localparam int BURST_LEN = 16;
  localparam int SLACK     = 2;
  localparam int LW        = $clog2(DEPTH) + 2;

  logic          clk;
  logic          reset;
  logic          i_clear;
  logic [31:0]   i_data;
  logic          i_valid;
  logic          o_room;
  logic [31:0]   o_data;
  logic          o_valid;
  logic          i_ready;
  logic [LW-1:0] o_level;
  logic          o_overflow;

  int compared;
  int mismatched;

  // Reference model: array contents as a queue plus the output slot.
  logic [31:0] mQ[$];
  logic        mValid;
  logic [31:0] mData;
  logic        mOverflow;
  logic        mRoom;

  // Words actually handed to the consumer, for ordering checks.
  logic [31:0] popLog[$];

  dma_burst_fifo #(
    .DEPTH(DEPTH),
    .BURST_LEN(BURST_LEN),
    .SLACK(SLACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_clear(i_clear),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_room(o_room),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_level(o_level),
    .o_overflow(o_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mValid    = 1'b0;
    mData     = '0;
    mOverflow = 1'b0;
    mRoom     = 1'b1;
  endtask

  // One clock of the buffer described in plain queue terms.
  task automatic modelStep(input logic v, input logic [31:0] d, input logic r, input logic c);
    bit load;
    int afterRead;
    if (c) begin
      mQ.delete();
      mValid    = 1'b0;
      mOverflow = 1'b0;
      mRoom     = 1'b1;
      return;
    end
    load      = (!mValid || r) && (mQ.size() != 0);
    afterRead = mQ.size() - (load ? 1 : 0);
    if (load) begin
      mData  = mQ.pop_front();
      mValid = 1'b1;
    end else if (r) begin
      mValid = 1'b0;
    end
    if (v) begin
      if (afterRead < DEPTH) mQ.push_back(d);
      else mOverflow = 1'b1;
    end
    mRoom = (DEPTH - mQ.size()) >= (BURST_LEN + SLACK);
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(o_valid), 32'(mValid));
    if (mValid) checkOutput({tag, ".data"}, o_data, mData);
    checkOutput({tag, ".level"}, 32'(o_level), 32'(mQ.size() + (mValid ? 1 : 0)));
    checkOutput({tag, ".room"}, 32'(o_room), 32'(mRoom));
    checkOutput({tag, ".ovf"}, 32'(o_overflow), 32'(mOverflow));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                               input logic c, input string tag);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_clear = c;
    #1;
    if (!c && r && o_valid) popLog.push_back(o_data);
    @(posedge clk);
    modelStep(v, d, r, c);
    #1;
    compareAll(tag);
  endtask

  task automatic idleCycles(input int n, input logic r, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, r, 1'b0, tag);
  endtask

  // Reset asserted between clock edges must act at once.
  task automatic asyncReset(input string tag);
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clear = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    compareAll({tag, ".imm"});
    checkOutput({tag, ".odata"}, o_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    compareAll({tag, ".post"});
  endtask

  task automatic checkPopLog(input string tag, input int n, input logic [31:0] base);
    checkOutput({tag, ".count"}, 32'(popLog.size()), 32'(n));
    for (int k = 0; k < n && k < popLog.size(); k++) begin
      checkOutput($sformatf("%s.word%0d", tag, k), popLog[k], base + 32'(k));
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset   = 1'b1;
    i_clear = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    modelReset();
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset and idle state.
    compareAll("t1");
    checkOutput("t1.room", 32'(o_room), 32'h1);
    checkOutput("t1.level", 32'(o_level), 32'h0);
    checkOutput("t1.odata", o_data, 32'h0);

    // Streaming with consumer ready: two-cycle latency, no gaps.
    popLog.delete();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0, "t2");
      if (k == 0) checkOutput("t2.latN1", 32'(o_valid), 32'h0);
      if (k == 1) begin
        checkOutput("t2.latN2", 32'(o_valid), 32'h1);
        checkOutput("t2.first", o_data, 32'h100);
      end
    end
    idleCycles(4, 1'b1, "t2i");
    checkPopLog("t2.order", 16, 32'h100);
    checkOutput("t2.end", 32'(o_valid), 32'h0);

    // Room threshold.
    for (int k = 0; k < 47; k++) applyStimulus(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0, "t3");
    checkOutput("t3.room47", 32'(o_room), 32'h1);
    checkOutput("t3.level47", 32'(o_level), 32'd47);
    applyStimulus(1'b1, 32'h32F, 1'b0, 1'b0, "t3");
    checkOutput("t3.room48", 32'(o_room), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, "t3p");
    checkOutput("t3.roomBack", 32'(o_room), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, "t3c");

    // Overflow: 66 writes, last dropped, first 65 drain in order.
    for (int k = 0; k < 66; k++) applyStimulus(1'b1, 32'h400 + 32'(k), 1'b0, 1'b0, "t4");
    checkOutput("t4.level", 32'(o_level), 32'd65);
    checkOutput("t4.ovf", 32'(o_overflow), 32'h1);
    popLog.delete();
    idleCycles(70, 1'b1, "t4d");
    checkPopLog("t4.order", 65, 32'h400);
    checkOutput("t4.ovfSticky", 32'(o_overflow), 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, "t4c");

    // Full array with same-cycle pop accepts the write.
    for (int k = 0; k < 65; k++) applyStimulus(1'b1, 32'h500 + 32'(k), 1'b0, 1'b0, "t5");
    checkOutput("t5.level", 32'(o_level), 32'd65);
    popLog.delete();
    applyStimulus(1'b1, 32'hABC, 1'b1, 1'b0, "t5w");
    checkOutput("t5.ovf", 32'(o_overflow), 32'h0);
    checkOutput("t5.levelKeep", 32'(o_level), 32'd65);
    idleCycles(70, 1'b1, "t5d");
    checkOutput("t5.count", 32'(popLog.size()), 32'd66);
    if (popLog.size() > 0) checkOutput("t5.last", popLog[popLog.size()-1], 32'hABC);

    // Clear mid-stream ignores the write and pop of its cycle.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h550 + 32'(k), 1'b0, 1'b0, "t6");
    applyStimulus(1'b1, 32'h777, 1'b1, 1'b1, "t6c");
    checkOutput("t6.clrValid", 32'(o_valid), 32'h0);
    checkOutput("t6.clrLevel", 32'(o_level), 32'h0);
    checkOutput("t6.clrRoom", 32'(o_room), 32'h1);
    popLog.delete();
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 32'h600 + 32'(k), 1'b1, 1'b0, "t6f");
    idleCycles(3, 1'b1, "t6i");
    checkPopLog("t6.fresh", 3, 32'h600);

    // Async reset in the middle of a burst.
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 32'h650 + 32'(k), 1'b0, 1'b0, "t6b");
    asyncReset("t6r");
    popLog.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h700 + 32'(k), 1'b1, 1'b0, "t6g");
    idleCycles(3, 1'b1, "t6h");
    checkPopLog("t6.afterRst", 4, 32'h700);

    // Randomized phases with different consumer readiness.
    for (int p = 0; p < 10; p++) begin
      int readyPct;
      readyPct = int'($urandom_range(10, 90));
      for (int k = 0; k < 300; k++) begin
        applyStimulus(($urandom % 100) < 75, $urandom, ($urandom % 100) < readyPct,
                      ($urandom % 500) == 0, "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
